mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cache-line width in bits for all line data ports.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_read  input  1  instruction-side line read request; level, held until i_resp.
REQ-006 i_address  input  ADDR_W  instruction-side line address.
REQ-007 i_rdata  output  LINE_W  instruction-side returned line.
REQ-008 i_resp  output  1  instruction-side one-cycle completion pulse.
REQ-009 d_read  input  1  data-side line read request; level, held until d_resp.
REQ-010 d_write  input  1  data-side line write request; level, held until d_resp.
REQ-011 d_address  input  ADDR_W  data-side line address.
REQ-012 d_wdata  input  LINE_W  data-side write line.
REQ-013 d_rdata  output  LINE_W  data-side returned line.
REQ-014 d_resp  output  1  data-side one-cycle completion pulse.
REQ-015 mem_read, mem_write  output  1 each  shared memory port commands.
REQ-016 mem_address  output  ADDR_W  shared port address.
REQ-017 mem_wdata  output  LINE_W  shared port write line.
REQ-018 mem_rdata  input  LINE_W  shared port read line, valid with mem_resp.
REQ-019 mem_resp  input  1  shared port completion, one cycle.

Function
REQ-020 FSM states IDLE, SERVE_I, SERVE_D, DONE; reset state IDLE.
REQ-021 IDLE: d_req = d_read|d_write; only i_read -> SERVE_I; only d_req -> SERVE_D; both -> side opposite to last_grant; none -> stay.
REQ-022 last_grant register (I/D), reset to I, updated on every IDLE->SERVE transition; guarantees round-robin, with D winning the first simultaneous request after reset.
REQ-023 On grant, address, write line and command are captured into registers; mem_* outputs driven only from these registers, first asserted the cycle after the request is seen in IDLE.
REQ-024 mem_read/mem_write held constant throughout SERVE_x until mem_resp; requester input changes during SERVE_x are ignored.
REQ-025 d_read and d_write both high at grant: treated as write (mem_write=1, mem_read=0).
REQ-026 SERVE_x with mem_resp=1: x_resp=1 same cycle (combinational), x_rdata=mem_rdata same cycle; next state DONE.
REQ-027 Other side's resp is 0 whenever not being served; i_rdata and d_rdata pass mem_rdata unconditionally.
REQ-028 DONE: all mem commands 0, both resp 0, exactly one cycle, then IDLE; gives requester one cycle to drop its request.
REQ-029 Minimum request-to-next-grant spacing: 3 cycles plus memory latency; a zero-latency memory (mem_resp on first SERVE cycle) is legal.
REQ-030 mem_resp in IDLE or DONE is ignored; no resp forwarded.
REQ-031 Never more than one mem command asserted; never both i_resp and d_resp in one cycle.

Reset
REQ-032 rst low asynchronously forces IDLE, last_grant=I, all mem_* command/address/wdata registers to 0, i_resp=d_resp=0.
REQ-033 Reset during SERVE_x abandons the transfer; no resp issued; requester re-issues after release.
REQ-034 First grant possible on first rising edge after rst goes high with a request present.

Verification
REQ-035 i_read=1, i_address=0x0000_1000, mem_resp after 4 cycles with mem_rdata=0xA5..A5 -> mem_read=1, mem_address=0x1000 from cycle 1, i_resp=1 with i_rdata=0xA5..A5, DONE one cycle, mem_read=0.
REQ-036 i_read and d_read both asserted in same cycle after reset -> D served first (SERVE_D), then I granted on the IDLE following DONE.
REQ-037 d_write=1, d_address=0x2000, d_wdata=0x1234..; change d_wdata mid-SERVE -> mem_wdata stays at captured value, mem_write=1 until mem_resp, d_resp pulse one cycle.
REQ-038 Back-to-back d_read requests while i_read held -> grants alternate D, I, D; i_read waits at most one D transaction.
REQ-039 rst low two cycles into SERVE_I -> mem_read=0 immediately, no i_resp, state IDLE; after release with i_read held, new grant next cycle.
REQ-040 mem_resp pulsed while IDLE -> no i_resp/d_resp, state unchanged; d_read=d_write=1 -> mem_write=1, mem_read=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester cache-line arbiter: instruction side and data side share one
// memory port. Round-robin on simultaneous requests, with registered memory
// commands and a one-cycle DONE gap after every transfer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transfer; arbitrate between i_read and d_read|d_write
// SERVE_I | instruction-side line read in flight, waiting for mem_resp
// SERVE_D | data-side read or write in flight, waiting for mem_resp
// DONE    | one quiet cycle so the requester can drop its request
module mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SERVE_I = 2'd1;
  localparam logic [1:0] S_SERVE_D = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              d_req;

  assign d_req = d_read | d_write;

  // Next-state, arbitration and command capture.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        // I wins when alone, or when both ask and D had the previous grant.
        if (i_read && (!d_req || last_grant_q == GRANT_D)) begin
          state_d       = S_SERVE_I;
          last_grant_d  = GRANT_I;
          mem_read_d    = 1'b1;
          mem_address_d = i_address;
        end else if (d_req) begin
          state_d       = S_SERVE_D;
          last_grant_d  = GRANT_D;
          // Read and write together is resolved as a write.
          mem_write_d   = d_write;
          mem_read_d    = ~d_write;
          mem_address_d = d_address;
          if (d_write) begin
            mem_wdata_d = d_wdata;
          end
        end
      end
      S_SERVE_I, S_SERVE_D: begin
        if (mem_resp) begin
          state_d     = S_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and captured memory command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GRANT_I;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  // Completion is forwarded combinationally, only to the side being served.
  assign i_resp  = (state_q == S_SERVE_I) && mem_resp;
  assign d_resp  = (state_q == S_SERVE_D) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter. Each table row is one clock
// cycle: inputs driven just after the rising edge, outputs checked on the
// falling edge. Reset-in-flight is exercised by a hand-written sequence.
module tb_mem_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int NVEC   = 30;

  logic              clk, rst;
  logic              i_read, i_resp, d_read, d_write, d_resp;
  logic [ADDR_W-1:0] i_address, d_address, mem_address;
  logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic              mem_read, mem_write, mem_resp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              ir, dr, dw;
    logic [ADDR_W-1:0] ia, da;
    logic [LINE_W-1:0] dwd;
    logic              mr;
    logic [LINE_W-1:0] mrd;
    logic              e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata;
    logic              e_ir, e_dr;
  } vec_t;

  vec_t vecs [NVEC];

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic ir, dr, dw, input logic [ADDR_W-1:0] ia, da,
                             input logic [LINE_W-1:0] dwd, input logic mr,
                             input logic [LINE_W-1:0] mrd, input logic e_rd, e_wr,
                             input logic [ADDR_W-1:0] e_addr, input logic [LINE_W-1:0] e_wdata,
                             input logic e_ir, e_dr);
    vec_t r;
    r.ir = ir; r.dr = dr; r.dw = dw; r.ia = ia; r.da = da; r.dwd = dwd;
    r.mr = mr; r.mrd = mrd; r.e_rd = e_rd; r.e_wr = e_wr; r.e_addr = e_addr;
    r.e_wdata = e_wdata; r.e_ir = e_ir; r.e_dr = e_dr;
    return r;
  endfunction

  // Invariants on every cycle outside reset: one command, one response.
  always @(negedge clk) begin
    if (rst) begin
      chk("one_cmd", {255'd0, mem_read & mem_write}, '0);
      chk("one_resp", {255'd0, i_resp & d_resp}, '0);
    end
  end

  initial begin
    logic [LINE_W-1:0] z, a5, f5a, w1, w2;
    z   = '0;
    a5  = {32{8'hA5}};
    f5a = {32{8'h5A}};
    w1  = {8{32'h1234_5678}};
    w2  = {8{32'hDEAD_BEEF}};

    // Single I read, 4-cycle latency; mem_resp in IDLE ignored.
    vecs[0]  = v(1,0,0,32'h1000,0,z,0,z,     0,0,32'h0000,z,0,0);
    vecs[1]  = v(1,0,0,32'h1000,0,z,0,z,     1,0,32'h1000,z,0,0);
    vecs[2]  = v(1,0,0,32'h1000,0,z,0,z,     1,0,32'h1000,z,0,0);
    vecs[3]  = v(1,0,0,32'h1000,0,z,0,z,     1,0,32'h1000,z,0,0);
    vecs[4]  = v(1,0,0,32'h1000,0,z,1,a5,    1,0,32'h1000,z,1,0);
    vecs[5]  = v(0,0,0,0,0,z,0,z,            0,0,32'h1000,z,0,0);
    vecs[6]  = v(0,0,0,0,0,z,1,a5,           0,0,32'h1000,z,0,0);
    // Simultaneous I and D after an I grant: D first, then I.
    vecs[7]  = v(1,1,0,32'h1000,32'h3000,z,0,z,   0,0,32'h1000,z,0,0);
    vecs[8]  = v(1,1,0,32'h1000,32'h3000,z,0,z,   1,0,32'h3000,z,0,0);
    vecs[9]  = v(1,1,0,32'h1000,32'h3000,z,1,f5a, 1,0,32'h3000,z,0,1);
    vecs[10] = v(1,0,0,32'h1000,0,z,0,z,          0,0,32'h3000,z,0,0);
    vecs[11] = v(1,0,0,32'h1000,0,z,0,z,          0,0,32'h3000,z,0,0);
    vecs[12] = v(1,0,0,32'h1000,0,z,1,a5,         1,0,32'h1000,z,1,0);
    vecs[13] = v(0,0,0,0,0,z,0,z,                 0,0,32'h1000,z,0,0);
    // D write; wdata and address change mid-transfer are ignored.
    vecs[14] = v(0,0,1,0,32'h2000,w1,0,z,  0,0,32'h1000,z,0,0);
    vecs[15] = v(0,0,1,0,32'h2000,w2,0,z,  0,1,32'h2000,w1,0,0);
    vecs[16] = v(0,0,1,0,32'h4000,w2,1,a5, 0,1,32'h2000,w1,0,1);
    vecs[17] = v(0,0,0,0,0,z,0,z,          0,0,32'h2000,w1,0,0);
    // Read+write together resolves to write.
    vecs[18] = v(0,1,1,0,32'h2040,w2,0,z,   0,0,32'h2000,w1,0,0);
    vecs[19] = v(0,1,1,0,32'h2040,w2,1,f5a, 0,1,32'h2040,w2,0,1);
    vecs[20] = v(0,0,0,0,0,z,0,z,           0,0,32'h2040,w2,0,0);
    // Contention with zero-latency memory: grants alternate I, D, I.
    vecs[21] = v(1,1,0,32'h1000,32'h3000,z,0,z,   0,0,32'h2040,w2,0,0);
    vecs[22] = v(1,1,0,32'h1000,32'h3000,z,1,a5,  1,0,32'h1000,w2,1,0);
    vecs[23] = v(0,1,0,0,32'h3000,z,0,z,          0,0,32'h1000,w2,0,0);
    vecs[24] = v(1,1,0,32'h1000,32'h3000,z,0,z,   0,0,32'h1000,w2,0,0);
    vecs[25] = v(1,1,0,32'h1000,32'h3000,z,1,f5a, 1,0,32'h3000,w2,0,1);
    vecs[26] = v(1,0,0,32'h1000,0,z,0,z,          0,0,32'h3000,w2,0,0);
    vecs[27] = v(1,1,0,32'h1000,32'h3000,z,0,z,   0,0,32'h3000,w2,0,0);
    vecs[28] = v(1,1,0,32'h1000,32'h3000,z,1,a5,  1,0,32'h1000,w2,1,0);
    // mem_resp during DONE is ignored.
    vecs[29] = v(0,0,0,0,0,z,1,f5a,               0,0,32'h1000,w2,0,0);

    rst = 1'b0;
    i_read = 0; d_read = 0; d_write = 0; i_address = '0; d_address = '0;
    d_wdata = '0; mem_rdata = '0; mem_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", {255'd0, mem_read}, '0);
    chk("rst_mem_write", {255'd0, mem_write}, '0);
    chk("rst_mem_addr", {224'd0, mem_address}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    rst = 1'b1;

    for (int n = 0; n < NVEC; n++) begin
      @(posedge clk);
      #1;
      i_read = vecs[n].ir; d_read = vecs[n].dr; d_write = vecs[n].dw;
      i_address = vecs[n].ia; d_address = vecs[n].da; d_wdata = vecs[n].dwd;
      mem_resp = vecs[n].mr; mem_rdata = vecs[n].mrd;
      @(negedge clk);
      chk($sformatf("v%0d mem_read", n), {255'd0, mem_read}, {255'd0, vecs[n].e_rd});
      chk($sformatf("v%0d mem_write", n), {255'd0, mem_write}, {255'd0, vecs[n].e_wr});
      chk($sformatf("v%0d mem_address", n), {224'd0, mem_address}, {224'd0, vecs[n].e_addr});
      chk($sformatf("v%0d mem_wdata", n), mem_wdata, vecs[n].e_wdata);
      chk($sformatf("v%0d i_resp", n), {255'd0, i_resp}, {255'd0, vecs[n].e_ir});
      chk($sformatf("v%0d d_resp", n), {255'd0, d_resp}, {255'd0, vecs[n].e_dr});
      if (vecs[n].e_ir) chk($sformatf("v%0d i_rdata", n), i_rdata, vecs[n].mrd);
      if (vecs[n].e_dr) chk($sformatf("v%0d d_rdata", n), d_rdata, vecs[n].mrd);
    end

    // Reset two cycles into SERVE_I abandons the transfer.
    @(posedge clk);
    #1;
    i_read = 1; d_read = 0; d_write = 0; i_address = 32'h5000; mem_resp = 0;
    mem_rdata = a5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst mem_read", {255'd0, mem_read}, {255'd0, 1'b1});
    #1;
    rst = 1'b0;
    mem_resp = 1;
    #1;
    chk("rst mem_read", {255'd0, mem_read}, '0);
    chk("rst i_resp", {255'd0, i_resp}, '0);
    chk("rst d_resp", {255'd0, d_resp}, '0);
    chk("rst mem_addr", {224'd0, mem_address}, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_resp = 0;
    @(negedge clk);
    chk("regrant mem_read", {255'd0, mem_read}, {255'd0, 1'b1});
    chk("regrant mem_addr", {224'd0, mem_address}, {224'd0, 32'h5000});
    mem_resp = 1;
    #1;
    chk("regrant i_resp", {255'd0, i_resp}, {255'd0, 1'b1});
    chk("regrant i_rdata", i_rdata, a5);
    @(posedge clk);
    #1;
    i_read = 0; mem_resp = 0;
    @(negedge clk);
    chk("done mem_read", {255'd0, mem_read}, '0);
    chk("done i_resp", {255'd0, i_resp}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
